// File: rtl/buf_ram_1p_param_pkg.sv
// rtl/buf_ram_1p_param_pkg.sv - shared pixel defaults and address helper for the word buffer
// Contents:
//   PIXEL_WIDTH      encoder-wide bits per pixel
//   CLR_VAL_DEFAULT  default fill value for the clear engine
//   addr_in_range()  true when a word address falls inside a DEPTH-word array
package buf_ram_1p_param_pkg;

  localparam int PIXEL_WIDTH = 8;

  localparam logic [PIXEL_WIDTH-1:0] CLR_VAL_DEFAULT = '0;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_1p_core.sv
// rtl/ram_1p_core.sv - behavioural single-port pixel array with per-pixel write mask
// Ports:
//   clk    in   rising-edge clock
//   en     in   access enable
//   we     in   write enable (qualified by en); otherwise a read
//   addr   in   word address, always < DEPTH (range-checked by the wrapper)
//   wmask  in   per-pixel write enable
//   wdata  in   write word
//   rdata  out  registered read word; changes only on a read
module ram_1p_core #(
  parameter int PIX_W   = 8,
  parameter int PIX_NUM = 8,
  parameter int DEPTH   = 128,
  parameter int AW      = 7
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic [PIX_NUM-1:0]       wmask,
  input  logic [PIX_W*PIX_NUM-1:0] wdata,
  output logic [PIX_W*PIX_NUM-1:0] rdata
);

  localparam int DW = PIX_W * PIX_NUM;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;
  logic [IW-1:0] idx;

  assign idx = addr[IW-1:0];

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int k = 0; k < PIX_NUM; k++) begin
        if (wmask[k]) begin
          mem[idx][k*PIX_W +: PIX_W] <= wdata[k*PIX_W +: PIX_W];
        end
      end
    end
  end

  // Read register holds its word across writes and idle cycles.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/buf_ram_1p_param.sv
// rtl/buf_ram_1p_param.sv - single-port pixel word buffer with clear engine and optional output register
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   ce          in   access enable
//   we          in   write enable, qualified by ce
//   addr        in   word address; addresses >= DEPTH drop writes and read as zero
//   wmask       in   per-pixel write enable
//   data_i      in   write word
//   data_o      out  read word, held between reads
//   rd_valid_o  out  one-cycle pulse marking a new data_o
//   clr_i       in   start filling the whole array with CLR_VAL
//   busy_o      out  high while the clear engine owns the array
module buf_ram_1p_param
  import buf_ram_1p_param_pkg::*;
#(
  parameter int               PIX_W   = PIXEL_WIDTH,
  parameter int               PIX_NUM = 8,
  parameter int               DEPTH   = 128,
  parameter int               AW      = 7,
  parameter int               OUT_REG = 0,
  parameter logic [PIX_W-1:0] CLR_VAL = PIX_W'(CLR_VAL_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic [PIX_NUM-1:0]       wmask,
  input  logic [PIX_W*PIX_NUM-1:0] data_i,
  output logic [PIX_W*PIX_NUM-1:0] data_o,
  output logic                     rd_valid_o,
  input  logic                     clr_i,
  output logic                     busy_o
);

  localparam int               DW        = PIX_W * PIX_NUM;
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DW-1:0]    CLR_WORD  = {PIX_NUM{CLR_VAL}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rd1_q, rd1_d;
  logic          zero_q, zero_d;

  logic          busy;
  logic          in_range;
  logic          access;
  logic          acc_rd;
  logic          acc_wr;

  logic                core_en;
  logic                core_we;
  logic [AW-1:0]       core_addr;
  logic [PIX_NUM-1:0]  core_wmask;
  logic [DW-1:0]       core_wdata;
  logic [DW-1:0]       core_rdata;
  logic [DW-1:0]       rd_data1;

  // Access qualification and clear FSM.
  always_comb begin
    busy     = (state_q == ST_CLEAR);
    in_range = addr_in_range(32'(addr), DEPTH);
    // rst is included so nothing reaches the unreset array while reset is held.
    access   = ce && !busy && !rst;
    acc_rd   = access && !we;
    acc_wr   = access && we && in_range;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A same-cycle access is handled below; the clear begins next cycle.
        if (clr_i && !rst) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // clr_i is not looked at here, so a repeated request cannot restart the sweep.
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Array port mux: the clear engine takes the port outright while busy.
  always_comb begin
    core_en    = 1'b0;
    core_we    = 1'b0;
    core_addr  = addr;
    core_wmask = wmask;
    core_wdata = data_i;
    if (busy) begin
      core_en    = 1'b1;
      core_we    = 1'b1;
      core_addr  = cnt_q;
      core_wmask = '1;
      core_wdata = CLR_WORD;
    end else begin
      // Out-of-range reads never touch the array; zero_q supplies their data.
      core_en = acc_wr || (acc_rd && in_range);
      core_we = we;
    end
  end

  // Read stage 1: valid pulse plus a sticky "last read was out of range" flag,
  // which also forces data_o to zero out of reset.
  always_comb begin
    rd1_d  = acc_rd;
    zero_d = zero_q;
    if (acc_rd) begin
      zero_d = !in_range;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd1_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd1_q   <= rd1_d;
      zero_q  <= zero_d;
    end
  end

  assign busy_o   = busy;
  assign rd_data1 = zero_q ? '0 : core_rdata;

  ram_1p_core #(
    .PIX_W   (PIX_W),
    .PIX_NUM (PIX_NUM),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_core (
    .clk   (clk),
    .en    (core_en),
    .we    (core_we),
    .addr  (core_addr),
    .wmask (core_wmask),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] data2_q, data2_d;
      logic          rd2_q, rd2_d;

      // Reads already in stage 1 when a clear starts still land here,
      // since the clear engine only writes and leaves the read register alone.
      always_comb begin
        data2_d = data2_q;
        rd2_d   = rd1_q;
        if (rd1_q) begin
          data2_d = rd_data1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data2_q <= '0;
          rd2_q   <= 1'b0;
        end else begin
          data2_q <= data2_d;
          rd2_q   <= rd2_d;
        end
      end

      assign data_o     = data2_q;
      assign rd_valid_o = rd2_q;
    end else begin : g_no_out_reg
      assign data_o     = rd_data1;
      assign rd_valid_o = rd1_q;
    end
  endgenerate

endmodule

// File: tb/tb_buf_ram_1p_param.sv
// tb/tb_buf_ram_1p_param.sv - self-checking bench for buf_ram_1p_param, OUT_REG=0 and OUT_REG=1 side by side
module tb_buf_ram_1p_param;

  localparam int              DEPTH    = 100;
  localparam int              AW       = 7;
  localparam logic [7:0]      CLR      = 8'h80;
  localparam logic [63:0]     CLR_WORD = {8{CLR}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, we = 1'b0, clr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]  wmask = '0;
  logic [63:0] din = '0;
  logic [63:0] d0, d1;
  logic        v0, v1, b0, b1;

  always #5 clk = ~clk;

  buf_ram_1p_param #(
    .PIX_W(8), .PIX_NUM(8), .DEPTH(DEPTH), .AW(AW), .OUT_REG(0), .CLR_VAL(CLR)
  ) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .wmask(wmask),
    .data_i(din), .data_o(d0), .rd_valid_o(v0), .clr_i(clr), .busy_o(b0)
  );

  buf_ram_1p_param #(
    .PIX_W(8), .PIX_NUM(8), .DEPTH(DEPTH), .AW(AW), .OUT_REG(1), .CLR_VAL(CLR)
  ) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .wmask(wmask),
    .data_i(din), .data_o(d1), .rd_valid_o(v1), .clr_i(clr), .busy_o(b1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: array contents, clear progress, read results by delivery latency.
  logic [63:0] mem_m [DEPTH];
  bit          busy_m;
  int          clr_addr_m;
  bit          rdv_now, rdv_prev;
  logic [63:0] rdd_now, rdd_prev;
  logic [63:0] hold0, hold1;
  bit          started = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_m = 0; clr_addr_m = 0;
      rdv_now = 0; rdv_prev = 0; rdd_now = '0; rdd_prev = '0;
      hold0 = '0; hold1 = '0;
      started = 1'b1;
    end else begin
      bit rv;
      logic [63:0] rd;
      int a;
      rv = 0; rd = '0; a = int'(addr);
      if (busy_m) begin
        mem_m[clr_addr_m] = CLR_WORD;
        clr_addr_m++;
        if (clr_addr_m == DEPTH) busy_m = 0;
      end else begin
        if (ce) begin
          if (we) begin
            if (a < DEPTH)
              for (int k = 0; k < 8; k++)
                if (wmask[k]) mem_m[a][k*8 +: 8] = din[k*8 +: 8];
          end else begin
            rv = 1;
            rd = (a < DEPTH) ? mem_m[a] : '0;
          end
        end
        if (clr) begin
          busy_m = 1; clr_addr_m = 0;
        end
      end
      rdv_prev = rdv_now; rdd_prev = rdd_now;
      rdv_now  = rv;      rdd_now  = rd;
      if (rdv_now)  hold0 = rdd_now;
      if (rdv_prev) hold1 = rdd_prev;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy0",  b0, busy_m);
      chk("busy1",  b1, busy_m);
      chk("valid0", v0, rdv_now);
      chk("data0",  d0, hold0);
      chk("valid1", v1, rdv_prev);
      chk("data1",  d1, hold1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce = 0; we = 0; clr = 0;
  endtask

  task automatic wr(input int a, input logic [63:0] d, input logic [7:0] m);
    ce = 1; we = 1; addr = AW'(a); din = d; wmask = m;
    step();
    ce = 0; we = 0;
  endtask

  task automatic rd(input int a);
    ce = 1; we = 0; addr = AW'(a);
    step();
    ce = 0;
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i + 1);
    return {8{b}};
  endfunction

  logic [63:0] fill_w [DEPTH];
  int          busy_cnt;

  initial begin
    rst = 1;
    repeat (3) step();
    chk("rst_data0",  d0, 64'h0);
    chk("rst_valid0", v0, 1'b0);
    chk("rst_data1",  d1, 64'h0);
    chk("rst_busy0",  b0, 1'b0);
    rst = 0;
    step();

    // Write then immediately read the same word.
    wr(5, 64'h0102030405060708, 8'hFF);
    rd(5);
    chk("basic_valid0", v0, 1'b1);
    chk("basic_data0",  d0, 64'h0102030405060708);
    step();
    chk("basic_valid0_drop", v0, 1'b0);
    chk("basic_hold0",  d0, 64'h0102030405060708);
    chk("basic_valid1", v1, 1'b1);
    chk("basic_data1",  d1, 64'h0102030405060708);

    // Partial write mask.
    wr(9, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    wr(9, 64'h0, 8'h0F);
    rd(9);
    chk("mask_data0", d0, 64'hFFFFFFFF00000000);

    // Out-of-range write dropped, read returns zero.
    wr(99, 64'hA5A5A5A5A5A5A5A5, 8'hFF);
    wr(120, 64'hDEADBEEFCAFEF00D, 8'hFF);
    rd(120);
    chk("oor_valid0", v0, 1'b1);
    chk("oor_data0",  d0, 64'h0);
    rd(99);
    chk("last_word0", d0, 64'hA5A5A5A5A5A5A5A5);

    // Back-to-back reads through the registered output.
    for (int i = 0; i < 4; i++) wr(i, pat(i), 8'hFF);
    ce = 1; we = 0;
    for (int i = 0; i < 4; i++) begin
      addr = AW'(i);
      step();
      if (i > 0) begin
        chk("b2b_valid1", v1, 1'b1);
        chk("b2b_data1",  d1, pat(i - 1));
      end
    end
    ce = 0;
    step();
    chk("b2b_valid1_last", v1, 1'b1);
    chk("b2b_data1_last",  d1, pat(3));
    step();
    chk("b2b_valid1_end",  v1, 1'b0);

    // Fill, then clear together with a read while hammering ce.
    for (int a = 0; a < DEPTH; a++) wr(a, {$urandom, $urandom}, 8'hFF);
    ce = 1; we = 0; addr = AW'(7); clr = 1;
    step();
    clr = 0; ce = 0;
    chk("clr_read_valid0", v0, 1'b1);
    busy_cnt = 0;
    for (int k = 0; k < 300 && b0; k++) begin
      busy_cnt++;
      ce = 1'($urandom); we = 1'($urandom); addr = AW'($urandom_range(0, 127));
      wmask = 8'($urandom); din = {$urandom, $urandom}; clr = 1'($urandom);
      step();
    end
    idle();
    chk("clr_busy_cycles", 64'(busy_cnt), 64'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      rd(a);
      chk("clr_word0", d0, CLR_WORD);
    end

    // Reset part way through a clear.
    for (int a = 0; a < DEPTH; a++) begin
      fill_w[a] = {$urandom, $urandom};
      wr(a, fill_w[a], 8'hFF);
    end
    clr = 1;
    step();
    clr = 0;
    repeat (40) step();
    rst = 1;
    #1;
    chk("abort_busy0", b0, 1'b0);
    chk("abort_busy1", b1, 1'b0);
    step();
    rst = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd(a);
      chk("abort_word0", d0, (a < 40) ? CLR_WORD : fill_w[a]);
    end

    // Randomised traffic, including clears and short resets.
    for (int n = 0; n < 3000; n++) begin
      ce    = ($urandom % 4) != 0;
      we    = 1'($urandom);
      addr  = AW'($urandom_range(0, 127));
      wmask = 8'($urandom);
      din   = {$urandom, $urandom};
      clr   = ($urandom % 300) == 0;
      rst   = ($urandom % 700) == 0;
      step();
    end
    idle();
    rst = 0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buf_ram_1p_param.md
BUF_RAM_1P_PARAM -- requirements
Module: buf_ram_1p_param

Interface
REQ-001 SHALL have parameter PIX_W, default `PIXEL_WIDTH (8), bits per pixel.
REQ-002 SHALL have parameter PIX_NUM, default 8, pixels per word.
REQ-003 SHALL have parameter DEPTH, default 128, number of words; any value 2..4096 is legal.
REQ-004 SHALL have parameter AW, default 7, address width, with 2^AW >= DEPTH.
REQ-005 SHALL have parameter OUT_REG, default 0, adding one output register stage when set to 1.
REQ-006 SHALL have parameter CLR_VAL, default 0, PIX_W-bit pixel value written by the clear engine.
REQ-007 clk  in  1  sole clock; all logic rising-edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 ce  in  1  access enable, active-high.
REQ-010 we  in  1  write enable, active-high; qualified by ce.
REQ-011 addr  in  AW  word address.
REQ-012 wmask  in  PIX_NUM  per-pixel write enable; bit k covers data_i[k*PIX_W +: PIX_W].
REQ-013 data_i  in  PIX_W*PIX_NUM  write data.
REQ-014 data_o  out  PIX_W*PIX_NUM  read data, held between reads.
REQ-015 rd_valid_o  out  1  one-cycle pulse that qualifies a new data_o.
REQ-016 clr_i  in  1  request to fill the whole array with CLR_VAL.
REQ-017 busy_o  out  1  high while the clear engine owns the array.

Function
REQ-018 Read is accepted when ce=1, we=0 and busy_o=0; data_o and rd_valid_o SHALL update 1 cycle later if OUT_REG=0, or 2 cycles later if OUT_REG=1.
REQ-019 Back-to-back reads SHALL sustain 1 word per cycle, with rd_valid_o high on each corresponding cycle.
REQ-020 Write is accepted when ce=1, we=1 and busy_o=0; only pixels whose wmask bit is 1 SHALL change, and all other pixels keep their old value.
REQ-021 A write SHALL NOT change data_o or rd_valid_o; there is no write-through.
REQ-022 A read of an address written in the previous cycle SHALL return the newly written data.
REQ-023 If addr >= DEPTH, a write SHALL be dropped and a read SHALL return all-zero data with rd_valid_o asserted.
REQ-024 data_o SHALL hold its last value whenever rd_valid_o=0.
REQ-025 The FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clr_i=1, and CLEAR->IDLE after the write to word DEPTH-1.
REQ-026 In CLEAR, one word per cycle SHALL be written with all pixels = CLR_VAL, at ascending addresses 0..DEPTH-1 from an AW-bit counter.
REQ-027 busy_o SHALL be 1 in exactly the DEPTH cycles of CLEAR.
REQ-028 When clr_i and ce are high in the same IDLE cycle, the access SHALL complete normally and CLEAR starts the next cycle.
REQ-029 clr_i during CLEAR SHALL be ignored and SHALL NOT restart the counter.
REQ-030 ce during CLEAR SHALL be ignored, with no write, no read and no rd_valid_o.
REQ-031 Reads already in flight in the OUT_REG pipeline when CLEAR starts SHALL still complete.

Reset
REQ-032 rst SHALL asynchronously force data_o=0, rd_valid_o=0, busy_o=0, FSM=IDLE, clear counter=0, and clear any pipeline valids.
REQ-033 Array contents SHALL NOT be reset.
REQ-034 rst asserted mid-CLEAR SHALL abort the clear, leaving the array partially cleared.
REQ-035 No access SHALL be accepted while rst=1.

Structure
REQ-036 PIXEL_WIDTH and the CLR_VAL default SHALL come from the shared encoder defines/package; FSM state encodings SHALL be local to the module.
REQ-037 Storage SHALL be one sub-module, ram_1p_core, a behavioural single-port array with per-pixel write mask and registered read; the wrapper holds the FSM, the address mux, range checks and the output pipeline.

Verification
REQ-038 Reset, write 0x0102030405060708 to addr 5 with wmask=FF, read addr 5 (OUT_REG=0) -> rd_valid_o 1 cycle after the read with data_o=0x0102030405060708.
REQ-039 Write all-FF to addr 9, then write 0x00 with wmask=0x0F, read -> data_o=0xFFFFFFFF00000000.
REQ-040 OUT_REG=1, 4 back-to-back reads of addrs 0..3 -> 4 consecutive rd_valid_o pulses starting 2 cycles after the first read, data in order.
REQ-041 DEPTH=100, write to addr 120, then read 120 -> data_o=0 with rd_valid_o asserted, and a read of addr 99 is unchanged.
REQ-042 Fill the array, pulse clr_i with CLR_VAL=0x80 together with a read -> the read completes, busy_o is high for exactly DEPTH cycles, ce is ignored meanwhile, and every word then reads 0x80 in every pixel.
REQ-043 Assert rst at clear count 40 -> busy_o=0 immediately, words 0..39 read CLR_VAL, and words 40+ keep their old data.
